deser_rx: RTL and testbench

- Serial-to-parallel receiver for the shift-register datapath.
- Collects WIDTH bits shifted out of a universal shift register and presents them as one parallel word with a valid/ready handshake.
- Shift order is selectable per frame:
  - MSB-first: the sender shifts left and drives its bit WIDTH-1.
  - LSB-first: the sender shifts right and drives its bit 0.
- Holds one completed word in an output register and flags overrun if a new word completes while that register is still occupied.

---
 rtl/deser_rx_if.sv | 29 ++
 rtl/deser_rx.sv | 91 +++++++++
 tb/tb_deser_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/deser_rx_if.sv
// deser_rx_if: bundle between the serial sender/consumer side and deser_rx.
//   master : drives start, msb_first, ser_in, ser_valid, out_ready;
//            observes data_out, out_valid, busy, overrun, bit_cnt.
//   slave  : the receiver itself (directions mirrored).
interface deser_rx_if #(
    parameter int WIDTH = 4,
    localparam int CW   = $clog2(WIDTH)
);
    logic             start;
    logic             msb_first;
    logic             ser_in;
    logic             ser_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output start, msb_first, ser_in, ser_valid, out_ready,
        input  data_out, out_valid, busy, overrun, bit_cnt
    );

    modport slave (
        input  start, msb_first, ser_in, ser_valid, out_ready,
        output data_out, out_valid, busy, overrun, bit_cnt
    );
endinterface

// File: rtl/deser_rx.sv
// deser_rx: serial-to-parallel receiver.
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset, overrides everything
//   bus  : deser_rx_if.slave
//          start/msb_first open a frame from IDLE; ser_in/ser_valid deliver
//          bits; data_out/out_valid/out_ready form the output handshake;
//          busy marks RECV, overrun is sticky, bit_cnt counts frame bits.
// All outputs come straight from flops.
module deser_rx #(
    parameter int WIDTH = 4,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       clr,
    deser_rx_if.slave  bus
);
    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_RECV = 1'b1;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic             dir_q;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH-1:0] data_q;
    logic             vld_q;
    logic             busy_q;
    logic             ovr_q;
    logic [CW-1:0]    cnt_q;

    // Next shift value including the bit on ser_in this cycle; also the
    // word that gets loaded on the completing bit.
    always_comb begin
        sh_nxt = sh;
        if (dir_q) sh_nxt = {sh[WIDTH-2:0], bus.ser_in};
        else       sh_nxt = {bus.ser_in, sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            dir_q  <= 1'b0;
            sh     <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            // Consumer handshake; a completion below may re-set vld_q.
            if (vld_q && bus.out_ready) vld_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_RECV;
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        dir_q  <= bus.msb_first;
                    end
                end
                ST_RECV: begin
                    if (bus.ser_valid) begin
                        sh <= sh_nxt;
                        if (cnt_q == LAST) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                            cnt_q  <= '0;
                            // Register free, or being emptied this same cycle.
                            if (!vld_q || bus.out_ready) begin
                                data_q <= sh_nxt;
                                vld_q  <= 1'b1;
                            end else begin
                                ovr_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = vld_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = ovr_q;
    assign bus.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_deser_rx.sv
module tb_deser_rx;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    deser_rx_if #(.WIDTH(WIDTH)) bus ();
    deser_rx #(.WIDTH(WIDTH)) dut (.clk(clk), .clr(clr), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Compare data_out against the oldest word the scoreboard expects.
    task automatic check_pop(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s obs=%0h exp=<empty scoreboard>", tag, bus.data_out);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(bus.data_out), 32'(e));
        end
    endtask

    // Start cycle carries a junk valid bit that must be ignored, then the
    // WIDTH bits in transmit order; out_ready = rdy_last on the final bit.
    task automatic frame(input logic msb, input logic [WIDTH-1:0] w,
                         input logic rdy_last, input logic stored);
        bus.start = 1'b1; bus.msb_first = msb;
        bus.ser_valid = 1'b1; bus.ser_in = 1'b1;
        step();
        bus.start = 1'b0; bus.msb_first = ~msb;
        for (int i = 0; i < WIDTH; i++) begin
            bus.ser_valid = 1'b1;
            bus.ser_in    = msb ? w[WIDTH-1-i] : w[i];
            bus.out_ready = (i == WIDTH-1) ? rdy_last : 1'b0;
            step();
        end
        bus.ser_valid = 1'b0; bus.out_ready = 1'b0;
        if (stored) exp_q.push_back(w);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic       v_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic       b_pat [7] = '{0, 1, 1, 1, 1, 0, 0};
        int         c_pat [7] = '{1, 1, 1, 2, 3, 3, 0};

        bus.start = 0; bus.msb_first = 0; bus.ser_in = 0;
        bus.ser_valid = 0; bus.out_ready = 0;
        clr = 1'b1;
        step(); step();
        check("rst_valid",   32'(bus.out_valid), 0);
        check("rst_busy",    32'(bus.busy), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_cnt",     32'(bus.bit_cnt), 0);
        check("rst_data",    32'(bus.data_out), 0);
        clr = 1'b0;

        // 1: MSB-first 1,0,1,1
        bus.start = 1; bus.msb_first = 1; step(); bus.start = 0;
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_cnt0", 32'(bus.bit_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] w1 = 4'b1011;
            bus.ser_valid = 1; bus.ser_in = w1[3-i];
            step();
            check($sformatf("t1_cnt%0d", i + 1), 32'(bus.bit_cnt), 32'((i + 1) % 4));
        end
        bus.ser_valid = 0;
        exp_q.push_back(4'b1011);
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_busy_done", 32'(bus.busy), 0);
        check_pop("t1_data");
        consume();
        check("t1_consumed", 32'(bus.out_valid), 0);

        // 2: LSB-first 1,0,1,1 -> 1101
        frame(1'b0, 4'b1101, 1'b0, 1'b1);
        check("t2_valid", 32'(bus.out_valid), 1);
        check_pop("t2_data");
        consume();
        check("t2_consumed", 32'(bus.out_valid), 0);
        check("t2_hold", 32'(bus.data_out), 32'h0000_000D);
        consume();
        check("t2_ready_idle", 32'(bus.out_valid), 0);

        // 3: stalls, with start/msb_first toggled mid-frame
        bus.start = 1; bus.msb_first = 1; step();
        for (int i = 0; i < 7; i++) begin
            bus.start = v_pat[i] ? 1'b0 : 1'b1;
            bus.msb_first = 1'(i);
            bus.ser_valid = v_pat[i];
            bus.ser_in = b_pat[i];
            step();
            check($sformatf("t3_cnt%0d", i), 32'(bus.bit_cnt), 32'(c_pat[i]));
        end
        bus.start = 0; bus.ser_valid = 0;
        exp_q.push_back(4'b0110);
        check("t3_valid", 32'(bus.out_valid), 1);
        check("t3_busy", 32'(bus.busy), 0);
        check_pop("t3_data");
        consume();

        // 4: overrun, back-to-back frames
        frame(1'b1, 4'hA, 1'b0, 1'b1);
        check_pop("t4_first");
        check("t4_ovr0", 32'(bus.overrun), 0);
        frame(1'b1, 4'h5, 1'b0, 1'b0);
        check("t4_data_kept", 32'(bus.data_out), 32'hA);
        check("t4_ovr1", 32'(bus.overrun), 1);
        check("t4_valid", 32'(bus.out_valid), 1);
        consume();
        check("t4_consumed", 32'(bus.out_valid), 0);
        check("t4_ovr_sticky", 32'(bus.overrun), 1);
        step(); step();
        check("t4_ovr_sticky2", 32'(bus.overrun), 1);
        clr = 1; step(); clr = 0;
        check("t4_ovr_clr", 32'(bus.overrun), 0);

        // 5: simultaneous consume and load
        frame(1'b1, 4'h3, 1'b0, 1'b1);
        check_pop("t5_first");
        exp_q.delete();
        frame(1'b1, 4'hC, 1'b1, 1'b1);
        check_pop("t5_replace");
        check("t5_valid", 32'(bus.out_valid), 1);
        check("t5_ovr", 32'(bus.overrun), 0);
        consume();
        check("t5_consumed", 32'(bus.out_valid), 0);

        // 6: clr mid-frame, then clean frame
        bus.start = 1; bus.msb_first = 1; step(); bus.start = 0;
        bus.ser_valid = 1; bus.ser_in = 1; step(); step();
        check("t6_cnt_mid", 32'(bus.bit_cnt), 2);
        clr = 1; step(); clr = 0; bus.ser_valid = 0;
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_cnt", 32'(bus.bit_cnt), 0);
        check("t6_valid", 32'(bus.out_valid), 0);
        frame(1'b1, 4'b1001, 1'b0, 1'b1);
        check("t6_valid2", 32'(bus.out_valid), 1);
        check_pop("t6_data");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
